// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one UART transmit path
// between NUM_REQ requesters. The block grants one byte at a time, holds
// tx_start until the UART reports tx_done, and then reports completion or
// timeout back to the owning requester.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 400000,
  parameter int TO_W    = 20,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [16:0]          cfg_baud,
  input  logic [3:0]           cfg_length,
  input  logic                 cfg_parity_type,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_stop2,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic [ID_W-1:0]      cur_id,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data,
  output logic [16:0]          uart_baud,
  output logic [3:0]           uart_length,
  output logic                 uart_parity_type,
  output logic                 uart_parity_en,
  output logic                 uart_stop2,
  input  logic                 uart_tx_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    WAIT_LOW  = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [TO_W-1:0]      timer_q, timer_d;
  logic [1:0]           sync_q, sync_d;
  logic                 done_dly_q, done_dly_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic                 start_q, start_d;
  logic [7:0]           data_q, data_d;
  logic [16:0]          baud_q, baud_d;
  logic [3:0]           len_q, len_d;
  logic                 ptype_q, ptype_d;
  logic                 pen_q, pen_d;
  logic                 stop2_q, stop2_d;

  logic                 done_s;
  logic                 rise_s;
  logic                 win_valid_s;
  logic [ID_W-1:0]      win_id_s;

  // Synchroniser and edge-detect delay for the tx_clk-domain tx_done.
  always_comb begin
    sync_d     = {sync_q[0], uart_tx_done};
    done_dly_d = sync_q[1];
    done_s     = sync_q[1];
    rise_s     = done_s & ~done_dly_q;
  end

  // Round-robin search: first set request at or after ptr, wrapping.
  always_comb begin
    win_valid_s = 1'b0;
    win_id_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int  idx;
      logic hit;
      idx = int'(ptr_q) + k;
      idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
      hit = ~win_valid_s & req[idx];
      win_id_s    = hit ? ID_W'(idx) : win_id_s;
      win_valid_s = win_valid_s | hit;
    end
  end

  // Next-state logic for the grant / wait-done / wait-low sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = '0;
    cur_id_d = cur_id_q;
    start_d  = start_q;
    data_d   = data_q;
    baud_d   = baud_q;
    len_d    = len_q;
    ptype_d  = ptype_q;
    pen_d    = pen_q;
    stop2_d  = stop2_q;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          gnt_d[win_id_s] = 1'b1;
          cur_id_d        = win_id_s;
          ptr_d           = (win_id_s == ID_LAST) ? '0 : (win_id_s + ID_W'(1));
          data_d          = req_data[8*int'(win_id_s) +: 8];
          baud_d          = cfg_baud;
          len_d           = cfg_length;
          ptype_d         = cfg_parity_type;
          pen_d           = cfg_parity_en;
          stop2_d         = cfg_stop2;
          start_d         = 1'b1;
          timer_d         = '0;
          state_d         = WAIT_DONE;
        end else begin
          start_d = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        // tx_start stays high so the slower tx_clk domain is sure to see it.
        timer_d = timer_q + TO_W'(1);
        if (rise_s) begin
          start_d          = 1'b0;
          done_d[cur_id_q] = 1'b1;
          state_d          = WAIT_LOW;
        end else if (timer_q == TO_LAST) begin
          start_d         = 1'b0;
          err_d[cur_id_q] = 1'b1;
          state_d         = WAIT_LOW;
        end else begin
          start_d = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_LOW: begin
        // Wait for tx_done to drop so a stale high level cannot finish the next frame.
        if (!done_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      timer_q    <= '0;
      sync_q     <= 2'b00;
      done_dly_q <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      cur_id_q   <= '0;
      start_q    <= 1'b0;
      data_q     <= 8'h00;
      baud_q     <= 17'd0;
      len_q      <= 4'd0;
      ptype_q    <= 1'b0;
      pen_q      <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      sync_q     <= sync_d;
      done_dly_q <= done_dly_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cur_id_q   <= cur_id_d;
      start_q    <= start_d;
      data_q     <= data_d;
      baud_q     <= baud_d;
      len_q      <= len_d;
      ptype_q    <= ptype_d;
      pen_q      <= pen_d;
      stop2_q    <= stop2_d;
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign err              = err_q;
  assign busy             = busy_q;
  assign cur_id           = cur_id_q;
  assign uart_tx_start    = start_q;
  assign uart_tx_data     = data_q;
  assign uart_baud        = baud_q;
  assign uart_length      = len_q;
  assign uart_parity_type = ptype_q;
  assign uart_parity_en   = pen_q;
  assign uart_stop2       = stop2_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a directed vector table for reset,
// grant, completion and config latching, then hand-written sequences for
// reset mid-frame, round-robin fairness and timeout.
module tb_uart_tx_sched;

  localparam int NR = 4;
  localparam int TO = 50;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [31:0]   req_data;
  logic [16:0]   cfg_baud;
  logic [3:0]    cfg_length;
  logic          cfg_parity_type;
  logic          cfg_parity_en;
  logic          cfg_stop2;
  logic [3:0]    gnt;
  logic [3:0]    done;
  logic [3:0]    err;
  logic          busy;
  logic [1:0]    cur_id;
  logic          uart_tx_start;
  logic [7:0]    uart_tx_data;
  logic [16:0]   uart_baud;
  logic [3:0]    uart_length;
  logic          uart_parity_type;
  logic          uart_parity_en;
  logic          uart_stop2;
  logic          uart_tx_done;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx_sched #(.NUM_REQ(NR), .TIMEOUT(TO), .TO_W(20)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_data         (req_data),
    .cfg_baud         (cfg_baud),
    .cfg_length       (cfg_length),
    .cfg_parity_type  (cfg_parity_type),
    .cfg_parity_en    (cfg_parity_en),
    .cfg_stop2        (cfg_stop2),
    .gnt              (gnt),
    .done             (done),
    .err              (err),
    .busy             (busy),
    .cur_id           (cur_id),
    .uart_tx_start    (uart_tx_start),
    .uart_tx_data     (uart_tx_data),
    .uart_baud        (uart_baud),
    .uart_length      (uart_length),
    .uart_parity_type (uart_parity_type),
    .uart_parity_en   (uart_parity_en),
    .uart_stop2       (uart_stop2),
    .uart_tx_done     (uart_tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        pe;
    logic        txd;
    logic [3:0]  e_gnt;
    logic [3:0]  e_done;
    logic [3:0]  e_err;
    logic        e_busy;
    logic        e_start;
    logic [7:0]  e_data;
    logic [1:0]  e_cur;
    logic        e_pe;
    logic [16:0] e_baud;
    logic [3:0]  e_len;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        step();
        if (gnt != 4'b0000) seen = 1'b1;
      end
    end
    check("gnt within budget", 32'(seen), 32'd1);
  endtask

  // Wait for a grant to id, model a tx_done pulse, check exact completion latency.
  task automatic serve_frame(input logic [1:0] id);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    wait_gnt();
    check("rr gnt", 32'(gnt), 32'(oh));
    check("rr cur_id", 32'(cur_id), 32'(id));
    check("rr start high", 32'(uart_tx_start), 32'd1);
    uart_tx_done = 1'b1;
    step();
    check("rr done early1", 32'(done), 32'd0);
    step();
    check("rr done early2", 32'(done), 32'd0);
    step();
    check("rr done", 32'(done), 32'(oh));
    check("rr start low", 32'(uart_tx_start), 32'd0);
    uart_tx_done = 1'b0;
  endtask

  initial begin
    int early;
    rst             = 1'b1;
    req             = 4'b0000;
    req_data        = 32'h0000_0000;
    cfg_baud        = 17'd115200;
    cfg_length      = 4'd8;
    cfg_parity_type = 1'b0;
    cfg_parity_en   = 1'b0;
    cfg_stop2       = 1'b0;
    uart_tx_done    = 1'b0;

    //            rst   req      data          pe    txd   gnt      done     err      busy  start data   cur    pe    baud        len
    tbl[0]  = '{1'b1, 4'hF, 32'h44332211, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 17'd0,      4'd0};
    tbl[1]  = '{1'b1, 4'hF, 32'h44332211, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 17'd0,      4'd0};
    tbl[2]  = '{1'b1, 4'hF, 32'h44332211, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 17'd0,      4'd0};
    tbl[3]  = '{1'b0, 4'hF, 32'h44332211, 1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 17'd115200, 4'd8};
    tbl[4]  = '{1'b0, 4'h0, 32'h44332211, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 17'd115200, 4'd8};
    tbl[5]  = '{1'b0, 4'h0, 32'h44332211, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 17'd115200, 4'd8};
    tbl[6]  = '{1'b0, 4'h0, 32'h44332211, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 17'd115200, 4'd8};
    tbl[7]  = '{1'b0, 4'h0, 32'h44332211, 1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0, 8'h11, 2'd0, 1'b1, 17'd115200, 4'd8};
    tbl[8]  = '{1'b0, 4'h4, 32'h44332211, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h11, 2'd0, 1'b1, 17'd115200, 4'd8};
    tbl[9]  = '{1'b0, 4'h4, 32'h44332211, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h11, 2'd0, 1'b1, 17'd115200, 4'd8};
    tbl[10] = '{1'b0, 4'h4, 32'h44332211, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h11, 2'd0, 1'b1, 17'd115200, 4'd8};
    tbl[11] = '{1'b0, 4'h4, 32'h44A52211, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 1'b1, 1'b1, 8'hA5, 2'd2, 1'b0, 17'd115200, 4'd8};
    tbl[12] = '{1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'hA5, 2'd2, 1'b0, 17'd115200, 4'd8};

    // Directed vector table: one clock per row, outputs checked after the edge.
    for (int i = 0; i < 13; i++) begin
      rst           = tbl[i].rst;
      req           = tbl[i].req;
      req_data      = tbl[i].data;
      cfg_parity_en = tbl[i].pe;
      uart_tx_done  = tbl[i].txd;
      step();
      check($sformatf("row%0d gnt", i),   32'(gnt),            32'(tbl[i].e_gnt));
      check($sformatf("row%0d done", i),  32'(done),           32'(tbl[i].e_done));
      check($sformatf("row%0d err", i),   32'(err),            32'(tbl[i].e_err));
      check($sformatf("row%0d busy", i),  32'(busy),           32'(tbl[i].e_busy));
      check($sformatf("row%0d start", i), 32'(uart_tx_start),  32'(tbl[i].e_start));
      check($sformatf("row%0d data", i),  32'(uart_tx_data),   32'(tbl[i].e_data));
      check($sformatf("row%0d cur", i),   32'(cur_id),         32'(tbl[i].e_cur));
      check($sformatf("row%0d pe", i),    32'(uart_parity_en), 32'(tbl[i].e_pe));
      check($sformatf("row%0d baud", i),  32'(uart_baud),      32'(tbl[i].e_baud));
      check($sformatf("row%0d len", i),   32'(uart_length),    32'(tbl[i].e_len));
    end

    // Reset while the frame for requester 2 is still in WAIT_DONE.
    rst = 1'b1;
    req = 4'b0000;
    step();
    check("midrst busy",  32'(busy),          32'd0);
    check("midrst start", 32'(uart_tx_start), 32'd0);
    check("midrst data",  32'(uart_tx_data),  32'd0);
    check("midrst cur",   32'(cur_id),        32'd0);
    check("midrst done",  32'(done),          32'd0);
    rst = 1'b0;
    uart_tx_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("late tx_done no done", 32'(done), 32'd0);
      check("late tx_done no err",  32'(err),  32'd0);
    end
    uart_tx_done = 1'b0;
    repeat (4) step();

    // Fairness with a held level request; first grant to 0 shows ptr was reset.
    req = 4'b1011;
    serve_frame(2'd0);
    serve_frame(2'd1);
    serve_frame(2'd3);
    serve_frame(2'd0);
    serve_frame(2'd1);
    req = 4'b0000;

    // Timeout: tx_done never arrives, err must come exactly TO cycles after gnt.
    req = 4'b0010;
    wait_gnt();
    check("to gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    early = 0;
    for (int k = 1; k < TO; k++) begin
      step();
      if (err != 4'b0000 || done != 4'b0000) early++;
    end
    check("to no early pulse", 32'(early), 32'd0);
    step();
    check("to err",   32'(err),           32'h2);
    check("to done",  32'(done),          32'h0);
    check("to start", 32'(uart_tx_start), 32'd0);
    check("to busy during err", 32'(busy), 32'd1);
    step();
    check("to busy low", 32'(busy), 32'd0);
    check("to err cleared", 32'(err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single transmit path of `uart_top` between `NUM_REQ` independent requesters. Each requester presents a byte. The scheduler grants one requester, latches its byte and the current frame configuration, and drives `tx_start` into the UART. It then waits for the UART's `tx_done` and returns a per-requester completion or timeout pulse. It sits between the client logic and `uart_top` and runs on the same system clock as `clk_gen`.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 400000: clk cycles allowed from start of frame to `tx_done` before abort.
- `TO_W`, default 20: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.
- `clk`  in  1  system clock; the block uses one clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  NUM_REQ  level request, one bit per requester.
- `req_data`  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- `cfg_baud`  in  17  baud select; latched at grant.
- `cfg_length`  in  4  data length 5..8; latched at grant.
- `cfg_parity_type`  in  1  parity type (1 = odd); latched at grant.
- `cfg_parity_en`  in  1  parity enable; latched at grant.
- `cfg_stop2`  in  1  second stop bit; latched at grant.
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse; byte accepted.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse; frame completed.
- `err`  out  NUM_REQ  one-hot, one-cycle pulse; frame timed out.
- `busy`  out  1  high whenever the state is not IDLE.
- `cur_id`  out  $clog2(NUM_REQ)  index of the requester that owns the UART.
- `uart_tx_start`  out  1  to `uart_top.tx_start`.
- `uart_tx_data`  out  8  to `uart_top.tx_data`.
- `uart_baud`  out  17  to `uart_top.baud`.
- `uart_length`  out  4  to `uart_top.length`.
- `uart_parity_type`  out  1  to `uart_top.parity_type`.
- `uart_parity_en`  out  1  to `uart_top.parity_en`.
- `uart_stop2`  out  1  to `uart_top.stop2`.
- `uart_tx_done`  in  1  from `uart_top.tx_done`; generated on `tx_clk`, so it is treated as asynchronous.

## Operation
- **`tx_done` synchronisation:** `uart_tx_done` passes through a 2-flop synchroniser to give `done_s`. A delay register gives `done_d`. The rising-edge term is `rise = done_s & ~done_d`.
- **Round-robin pointer `ptr`:** the search starts at `ptr` and wraps modulo NUM_REQ. The first set `req` bit found wins. After a grant to index i, `ptr` becomes (i+1) mod NUM_REQ.
- **State IDLE:** when `req != 0`, the next edge does all of the following:
  - `gnt[w]` = 1 and `cur_id` = w.
  - Latch `req_data[w]` and all `cfg_*` into the `uart_*` outputs.
  - `uart_tx_start` = 1, timer = 0, state goes to WAIT_DONE.
- **State WAIT_DONE:** `uart_tx_start` is held high. This is required because the UART samples `tx_start` on the slower `tx_clk`.
  - The timer increments every cycle.
  - On `rise`: `uart_tx_start` = 0, `done[cur_id]` pulses, state goes to WAIT_LOW.
  - Otherwise, when timer == TIMEOUT-1: `uart_tx_start` = 0, `err[cur_id]` pulses, state goes to WAIT_LOW.
  - If `rise` and the timeout occur in the same cycle, `rise` wins (`done` pulses, `err` does not).
- **State WAIT_LOW:** when `done_s == 0`, state goes to IDLE. This prevents a stale high `tx_done` from completing the next frame.
- **Stability:** the `uart_*` configuration and data outputs stay constant from grant until the next grant. Changes on `cfg_*` or `req_data` outside the grant edge have no effect.
- **Level requests:** `req` is a level. A requester that keeps `req` high re-enters arbitration in IDLE and is served again only after the other active requesters.
- **Grant/complete exclusivity:** `gnt`, `done` and `err` are never asserted for two indices in the same cycle. Only one frame is outstanding at a time.

## Timing
- **Reset values:**
  - `gnt` = `done` = `err` = 0; `busy` = 0; `cur_id` = 0.
  - `uart_tx_start` = 0; `uart_tx_data` = 0; `uart_baud` = 0; `uart_length` = 0; parity/stop outputs = 0.
  - `ptr` = 0, timer = 0, synchroniser flops = 0, state = IDLE.
- **Reset mid-frame:** all of the above take effect on the first edge with `rst` high, regardless of state. No `done` or `err` pulse is generated for the aborted frame.
- **Grant latency:** `req` sampled high in IDLE gives `gnt` and `uart_tx_start` high at the next edge (1 cycle).
- **Completion latency:** `uart_tx_done` rising (setup met) gives `done` pulse and `uart_tx_start` low 3 clk edges later (2 synchroniser stages + 1 registered state update).
- **Timeout:** `err` pulse asserted exactly TIMEOUT cycles after `gnt`.
- **Back-to-back minimum:** the next `gnt` comes no earlier than 1 cycle after `done_s` returns low.

## Test plan
- **Reset:** `rst` high for 3 cycles while `req` = 4'b1111 → all outputs at their reset values, no `gnt`. After release: `gnt` = 4'b0001 in the next cycle.
- **Single request:** `req[2]`, `req_data[2]` = 8'hA5, `cfg_length` = 8, `cfg_baud` = 115200 → `gnt` = 4'b0100, `uart_tx_data` = 8'hA5, `uart_tx_start` high. Model `tx_done` pulse → `done` = 4'b0100 3 cycles after it, `uart_tx_start` low.
- **Fairness:** `req` = 4'b1011 held continuously across frames → grant order 0, 1, 3, 0, 1.
- **Timeout:** `req[1]` with `uart_tx_done` tied low, TIMEOUT = 50 → `err` = 4'b0010 exactly 50 cycles after `gnt`, no `done`, `busy` low 1 cycle later.
- **Config latch:** `cfg_parity_en` toggled during WAIT_DONE → `uart_parity_en` unchanged until the next grant.
- **Reset mid-frame:** `rst` in WAIT_DONE, then a late `tx_done` → no `done` pulse, `ptr` = 0, `uart_tx_start` = 0.
